// File: rtl/axi_rr_arbiter_if.sv
// axi_rr_arbiter_if: request, shared-slave handshake and grant bundle around the round-robin arbiter
interface axi_rr_arbiter_if #(
   parameter int N_MST = 2
);
   localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
   logic [N_MST-1:0] m_arvalid_i;
   logic [N_MST-1:0] m_awvalid_i;
   logic             s_rvalid_i;
   logic             s_rready_i;
   logic             s_bvalid_i;
   logic             s_bready_i;
   logic [N_MST-1:0] gnt_o;
   logic [IW-1:0]    gnt_idx_o;
   logic             gnt_wr_o;
   logic             busy_o;
   logic             timeout_o;
   modport slave (
      input  m_arvalid_i, m_awvalid_i, s_rvalid_i, s_rready_i, s_bvalid_i, s_bready_i,
      output gnt_o, gnt_idx_o, gnt_wr_o, busy_o, timeout_o
   );
   modport master (
      output m_arvalid_i, m_awvalid_i, s_rvalid_i, s_rready_i, s_bvalid_i, s_bready_i,
      input  gnt_o, gnt_idx_o, gnt_wr_o, busy_o, timeout_o
   );
endinterface

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin AXI-Lite master arbiter for one shared slave; define ARB_TIMEOUT_EN for the grant watchdog
module axi_rr_arbiter #(
   parameter int N_MST          = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic           clk_i,
   input  logic           rst_i,
   axi_rr_arbiter_if.slave bus
);
   localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
   typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;
   state_t           state_q, state_d;
   logic [N_MST-1:0] req, gnt_q, gnt_d;
   logic [IW-1:0]    idx_q, idx_d, last_q, last_d, sel;
   logic             wr_q, wr_d, busy_q, busy_d, to_q, to_d;
   logic             found, done, expire;

   if (N_MST < 2 || N_MST > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("axi_rr_arbiter: unsupported parameter values");
   end

   assign req  = bus.m_arvalid_i | bus.m_awvalid_i;
   assign done = (state_q == GRANT_RD) ? bus.s_rvalid_i & bus.s_rready_i :
                 (state_q == GRANT_WR) ? bus.s_bvalid_i & bus.s_bready_i : 1'b1;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q;
   // watchdog counts clocks spent holding a grant and restarts with every new grant
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) cnt_q <= '0;
      else cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
   assign expire = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign expire = 1'b0;
`endif

   // first requester found searching circularly from the master after the last one served
   always_comb begin
      int c;
      c = 0;
      sel = last_q;
      found = 1'b0;
      for (int k = 1; k <= N_MST; k++) begin
         c = (int'(last_q) + k) % N_MST;
         if (!found && req[c[IW-1:0]]) begin
            found = 1'b1;
            sel = c[IW-1:0];
         end
      end
   end

   // next state and next values of the registered outputs; reads win when both channels request
   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      idx_d = idx_q;
      wr_d = wr_q;
      busy_d = busy_q;
      last_d = last_q;
      to_d = 1'b0;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = bus.m_arvalid_i[sel] ? GRANT_RD : GRANT_WR;
            gnt_d = N_MST'(1) << sel;
            idx_d = sel;
            wr_d = ~bus.m_arvalid_i[sel];
            busy_d = 1'b1;
         end
      end else if (done || expire) begin
         state_d = IDLE;
         gnt_d = '0;
         idx_d = '0;
         wr_d = 1'b0;
         busy_d = 1'b0;
         last_d = idx_q;
         to_d = expire & ~done;
      end
   end

   // state and output registers; reset makes master 0 the first winner
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q <= IDLE;
         gnt_q <= '0;
         idx_q <= '0;
         wr_q <= 1'b0;
         busy_q <= 1'b0;
         to_q <= 1'b0;
         last_q <= IW'(N_MST - 1);
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         idx_q <= idx_d;
         wr_q <= wr_d;
         busy_q <= busy_d;
         to_q <= to_d;
         last_q <= last_d;
      end

   assign bus.gnt_o     = gnt_q;
   assign bus.gnt_idx_o = idx_q;
   assign bus.gnt_wr_o  = wr_q;
   assign bus.busy_o    = busy_q;
   assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed checks of a 4-master arbiter with a 16-cycle watchdog limit
module tb_axi_rr_arbiter;
   localparam int N = 4;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   vectors = 0;
   int   errs = 0;
   int   cyc = 0;
   int   t0 = 0;
   logic seen_to;

   axi_rr_arbiter_if #(.N_MST(N)) bus ();
   axi_rr_arbiter #(.N_MST(N), .TIMEOUT_CYCLES(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   // cycle stamp used to measure grant spacing
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic status(input string tag, input logic [N-1:0] g, input logic [1:0] i,
                         input logic w, input logic b, input logic t = 1'b0);
      check({tag, ".gnt"}, 32'(bus.gnt_o), 32'(g));
      check({tag, ".idx"}, 32'(bus.gnt_idx_o), 32'(i));
      check({tag, ".wr"}, 32'(bus.gnt_wr_o), 32'(w));
      check({tag, ".busy"}, 32'(bus.busy_o), 32'(b));
      check({tag, ".timeout"}, 32'(bus.timeout_o), 32'(t));
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      bus.m_arvalid_i = '0;
      bus.m_awvalid_i = '0;
      bus.s_rvalid_i = 1'b0;
      bus.s_rready_i = 1'b1;
      bus.s_bvalid_i = 1'b0;
      bus.s_bready_i = 1'b1;
      #12;
      status("reset", 4'b0000, 0, 0, 0);
      rst_i = 1'b1;
      step();
      status("idle", 4'b0000, 0, 0, 0);
      bus.m_arvalid_i = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         status($sformatf("rr%0d", g), 4'(1 << (g % 4)), 2'(g % 4), 1'b0, 1'b1);
         if (g > 0) check("rr_spacing", cyc - t0, 5);
         t0 = cyc;
         step(3);
         bus.s_rvalid_i = 1'b1;
         step();
         bus.s_rvalid_i = 1'b0;
      end
      status("rr_done", 4'b0000, 0, 0, 0);
      bus.m_arvalid_i = 4'b0010;
      bus.m_awvalid_i = 4'b0010;
      step();
      status("both_rd", 4'b0010, 1, 0, 1);
      bus.s_bvalid_i = 1'b1;
      step();
      bus.s_bvalid_i = 1'b0;
      status("b_in_rd", 4'b0010, 1, 0, 1);
      bus.s_rvalid_i = 1'b1;
      step();
      bus.s_rvalid_i = 1'b0;
      bus.m_arvalid_i = '0;
      status("rd_done", 4'b0000, 0, 0, 0);
      step();
      status("then_wr", 4'b0010, 1, 1, 1);
      bus.m_awvalid_i = '0;
      step(3);
      status("wr_hold", 4'b0010, 1, 1, 1);
      bus.s_rvalid_i = 1'b1;
      step();
      bus.s_rvalid_i = 1'b0;
      status("r_in_wr", 4'b0010, 1, 1, 1);
      bus.s_bvalid_i = 1'b1;
      step();
      bus.s_bvalid_i = 1'b0;
      status("wr_done", 4'b0000, 0, 0, 0);
      bus.m_arvalid_i = 4'b0100;
      step();
      bus.m_arvalid_i = '0;
      status("wd_gnt", 4'b0100, 2, 0, 1);
`ifdef ARB_TIMEOUT_EN
      step(15);
      status("wd_hold", 4'b0100, 2, 0, 1);
      step();
      status("wd_rel", 4'b0000, 0, 0, 0, 1'b1);
      step();
      status("wd_pulse_end", 4'b0000, 0, 0, 0);
      bus.m_arvalid_i = 4'b0100;
      step();
      bus.m_arvalid_i = '0;
      status("prec_gnt", 4'b0100, 2, 0, 1);
      step(15);
      bus.s_rvalid_i = 1'b1;
      step();
      bus.s_rvalid_i = 1'b0;
      status("prec_rel", 4'b0000, 0, 0, 0);
`else
      seen_to = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         seen_to = seen_to | bus.timeout_o;
      end
      check("no_timeout", 32'(seen_to), 32'(0));
      status("hold100", 4'b0100, 2, 0, 1);
      bus.s_rvalid_i = 1'b1;
      step();
      bus.s_rvalid_i = 1'b0;
      status("hold_rel", 4'b0000, 0, 0, 0);
`endif
      bus.m_arvalid_i = 4'b0100;
      step();
      status("pre_rst", 4'b0100, 2, 0, 1);
      bus.m_arvalid_i = 4'b0101;
      #2 rst_i = 1'b0;
      #1 status("async_rst", 4'b0000, 0, 0, 0);
      step();
      rst_i = 1'b1;
      step();
      status("post_rst", 4'b0001, 0, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/axi_rr_arbiter.md
AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of requesting AXI-Lite masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in clocks (only used with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_arvalid_i  input  N_MST  per-master read-address request.
REQ-006 SHALL have port m_awvalid_i  input  N_MST  per-master write-address request.
REQ-007 SHALL have port s_rvalid_i / s_rready_i  input  1 each  shared-slave R-channel handshake.
REQ-008 SHALL have port s_bvalid_i / s_bready_i  input  1 each  shared-slave B-channel handshake.
REQ-009 SHALL have port gnt_o  output  N_MST  one-hot grant; routes the granted master to the slave.
REQ-010 SHALL have port gnt_idx_o  output  max(1,clog2(N_MST))  binary index of granted master.
REQ-011 SHALL have port gnt_wr_o  output  1  1 = granted transaction is a write, 0 = read.
REQ-012 SHALL have port busy_o  output  1  a grant is held.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse when the watchdog forces release.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_RD, GRANT_WR; all outputs registered.
REQ-015 SHALL treat master i as requesting when m_arvalid_i[i] | m_awvalid_i[i].
REQ-016 In IDLE, SHALL pick the first requester searching circularly from (last_idx+1) mod N_MST, wrapping past N_MST-1 to 0.
REQ-017 SHALL assert gnt_o/gnt_idx_o/busy_o on the cycle after requests are sampled in IDLE (1-cycle grant latency).
REQ-018 If the selected master raises both arvalid and awvalid, SHALL grant read (GRANT_RD, gnt_wr_o=0); write is served on a later arbitration.
REQ-019 SHALL hold grant and gnt_wr_o stable until completion, regardless of request deassertion.
REQ-020 SHALL complete GRANT_RD on s_rvalid_i & s_rready_i, GRANT_WR on s_bvalid_i & s_bready_i; SHALL ignore the other channel's handshake.
REQ-021 On completion SHALL return to IDLE next cycle with gnt_o=0, busy_o=0, and update last_idx to the released index.
REQ-022 SHALL always spend at least one IDLE cycle between grants; back-to-back grants therefore occur every completion+2 cycles minimum.
REQ-023 With no requests, SHALL stay in IDLE, outputs 0, last_idx unchanged.
REQ-024 SHALL guarantee no starvation: a continuously requesting master is granted within N_MST-1 other grants.

Reset
REQ-025 On rst_i=0, SHALL immediately (asynchronously) force IDLE, gnt_o=0, gnt_idx_o=0, gnt_wr_o=0, busy_o=0, timeout_o=0, last_idx=N_MST-1 (master 0 wins first).
REQ-026 Reset mid-grant SHALL drop the grant without waiting for completion; first arbitration after release follows REQ-016/017.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, SHALL count clocks in GRANT_RD/GRANT_WR (counter cleared on grant), and when count reaches TIMEOUT_CYCLES-1 without completion SHALL release as in REQ-021 and pulse timeout_o for one cycle.
REQ-028 Completion on the same cycle the count reaches the limit SHALL take precedence; timeout_o stays 0.
REQ-029 Without ARB_TIMEOUT_EN, SHALL instantiate no counter, tie timeout_o to 0, and hold grants indefinitely.

Verification
REQ-030 N_MST=2, after reset m_arvalid_i=2'b11 held -> cycle+1 gnt_o=01, gnt_wr_o=0; after s_rvalid&s_rready, next grant gnt_o=10.
REQ-031 N_MST=4, all four masters requesting continuously with 3-cycle slave responses -> grant order 0,1,2,3,0; each grant 5 cycles apart.
REQ-032 Master 1 asserts m_arvalid_i=1 and m_awvalid_i=1 together -> GRANT_RD first, then GRANT_WR on next arbitration when no others request; a B-handshake during GRANT_RD does not release.
REQ-033 Requests drop to 0 during GRANT_WR -> gnt_o unchanged until s_bvalid_i&s_bready_i; then busy_o=0 next cycle.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never responds -> release after 16 grant cycles, timeout_o high exactly one cycle; without macro timeout_o stays 0 and grant persists 100 cycles.
REQ-035 rst_i low for one cycle mid-GRANT_RD with master 2 granted -> outputs 0 immediately; after release master 0 granted first if requesting.
